// File: rtl/if_fetch_queue.sv
// Instruction-fetch engine: sequential/redirected address generation, one-cycle ROM
// reads, and a DEPTH-entry {pc, inst} queue drained by decode over valid/ready.
module if_fetch_queue #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 4,
    parameter logic [ADDR_W-1:0] INIT_PC = ADDR_W'(32'h0000_3000)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              branch_flag,
    input  logic [ADDR_W-1:0] branch_addr,
    input  logic              exc_flag,
    input  logic [ADDR_W-1:0] exc_addr,
    output logic              rom_en,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_rdata,
    output logic              if_valid,
    output logic [ADDR_W-1:0] if_pc,
    output logic [DATA_W-1:0] if_inst,
    input  logic              id_ready
);

    // Handshake: decode takes the head entry in any cycle where if_valid && id_ready;
    // the head is held stable while if_valid && !id_ready.

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = PW + 1;
    localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(4);

    logic [ADDR_W-1:0] fetch_pc;
    logic [ADDR_W-1:0] req_pc_q;
    logic              req_q;
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [CW-1:0]     count;
    logic [ADDR_W-1:0] pc_mem   [DEPTH];
    logic [DATA_W-1:0] inst_mem [DEPTH];

    logic              redirect;
    logic [ADDR_W-1:0] sel_target;
    logic [ADDR_W-1:0] target;
    logic              pop;
    logic              push;
    logic              issue;
    logic [CW:0]       occ;

    assign redirect   = exc_flag | branch_flag;
    assign sel_target = exc_flag ? exc_addr : branch_addr;
    assign target     = {sel_target[ADDR_W-1:2], 2'b00};
    assign rom_addr   = redirect ? target : fetch_pc;

    assign if_valid = (count != '0) && !redirect;
    assign pop      = if_valid && id_ready;
    assign push     = req_q && !redirect;

    // Occupancy as seen after this cycle's pop, counting the read still in flight;
    // a redirect empties everything, so the target fetch always goes out.
    assign occ    = {1'b0, count} + (CW+1)'(req_q) - (CW+1)'(pop);
    assign issue  = !rst && (redirect || (occ < (CW+1)'(DEPTH)));
    assign rom_en = issue;

    assign if_pc   = pc_mem[rd_ptr];
    assign if_inst = inst_mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc <= INIT_PC;
            req_q    <= 1'b0;
            req_pc_q <= INIT_PC;
        end else begin
            req_q <= issue;
            if (issue) begin
                fetch_pc <= rom_addr + PC_STEP;
                req_pc_q <= rom_addr;
            end else begin
                fetch_pc <= rom_addr;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || redirect) begin
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PW'(1);
            if (pop)
                rd_ptr <= rd_ptr + PW'(1);
            if (push && !pop)
                count <= count + CW'(1);
            else if (pop && !push)
                count <= count - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && push) begin
            pc_mem[wr_ptr]   <= req_pc_q;
            inst_mem[wr_ptr] <= rom_rdata;
        end
    end

    // The issue rule leaves room for every returning read.
    always_ff @(posedge clk) begin
        if (!rst && push)
            assert (count < CW'(DEPTH));
    end

endmodule

// File: tb/tb_if_fetch_queue.sv
// Bench for if_fetch_queue: directed scenarios plus randomized redirect/backpressure
// traffic, checked against a queue model of issued-but-not-consumed fetch addresses.
module tb_if_fetch_queue;

    localparam int unsigned DEPTH = 4;
    localparam logic [31:0] INIT_PC = 32'h0000_3000;
    localparam logic [31:0] WRAP_PC = 32'hFFFF_FFF8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        branch_flag = 1'b0;
    logic [31:0] branch_addr = '0;
    logic        exc_flag = 1'b0;
    logic [31:0] exc_addr = '0;
    logic        rom_en;
    logic [31:0] rom_addr;
    logic [31:0] rom_rdata;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
    logic        id_ready = 1'b1;

    logic        w_rom_en;
    logic [31:0] w_rom_addr;
    logic [31:0] w_rom_rdata;
    logic        w_if_valid;
    logic [31:0] w_if_pc;
    logic [31:0] w_if_inst;

    int err_cnt = 0;
    int chk_cnt = 0;
    bit checking = 1'b0;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    function automatic logic [31:0] rom_fn(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    always_ff @(posedge clk) if (rom_en)   rom_rdata   <= rom_fn(rom_addr);
    always_ff @(posedge clk) if (w_rom_en) w_rom_rdata <= rom_fn(w_rom_addr);

    if_fetch_queue #(.ADDR_W(32), .DATA_W(32), .DEPTH(DEPTH), .INIT_PC(INIT_PC)) dut (
        .clk(clk), .rst(rst),
        .branch_flag(branch_flag), .branch_addr(branch_addr),
        .exc_flag(exc_flag), .exc_addr(exc_addr),
        .rom_en(rom_en), .rom_addr(rom_addr), .rom_rdata(rom_rdata),
        .if_valid(if_valid), .if_pc(if_pc), .if_inst(if_inst),
        .id_ready(id_ready)
    );

    if_fetch_queue #(.ADDR_W(32), .DATA_W(32), .DEPTH(2), .INIT_PC(WRAP_PC)) dut_wrap (
        .clk(clk), .rst(rst),
        .branch_flag(1'b0), .branch_addr(32'h0),
        .exc_flag(1'b0), .exc_addr(32'h0),
        .rom_en(w_rom_en), .rom_addr(w_rom_addr), .rom_rdata(w_rom_rdata),
        .if_valid(w_if_valid), .if_pc(w_if_pc), .if_inst(w_if_inst),
        .id_ready(1'b1)
    );

    // ---------------- checking ----------------
    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s @%0t: got %h expected %h", tag, $time, got, exp);
        end
    endtask

    // ---------------- scoreboard / reference model ----------------
    // exp_q holds every address issued and not yet consumed, oldest first.
    logic [31:0] exp_q[$];
    logic [31:0] next_addr = INIT_PC;
    bit rst_p1 = 1'b1, rst_p2 = 1'b1, redir_p1 = 1'b0;
    logic [31:0] w_exp = WRAP_PC;
    int w_pops = 0;

    always @(negedge clk) begin
        if (checking) begin
            bit          redirect, exp_valid, pop_m, exp_en;
            logic [31:0] tgt, exp_addr;
            redirect = exc_flag | branch_flag;
            tgt = exc_flag ? exc_addr : branch_addr;
            tgt = tgt & ~32'h3;
            // Visible two cycles after a redirect, three after reset release.
            exp_valid = !(redirect | redir_p1 | rst_p1 | rst_p2);
            check_eq("if_valid", {31'b0, if_valid}, {31'b0, exp_valid});
            pop_m = exp_valid && id_ready;
            if (pop_m) begin
                if (exp_q.size() == 0) begin
                    check_eq("pop_on_empty_model", 32'd1, 32'd0);
                end else begin
                    check_eq("if_pc", if_pc, exp_q[0]);
                    check_eq("if_inst", if_inst, rom_fn(exp_q[0]));
                    void'(exp_q.pop_front());
                end
            end
            if (redirect) exp_q.delete();
            exp_en = !rst && (redirect || (exp_q.size() < DEPTH));
            check_eq("rom_en", {31'b0, rom_en}, {31'b0, exp_en});
            exp_addr = redirect ? tgt : next_addr;
            check_eq("rom_addr", rom_addr, exp_addr);
            if (rst) begin
                exp_q.delete();
                next_addr = INIT_PC;
            end else if (exp_en) begin
                exp_q.push_back(exp_addr);
                next_addr = exp_addr + 32'd4;
            end else begin
                next_addr = exp_addr;
            end
            rst_p2 = rst_p1;
            rst_p1 = rst;
            redir_p1 = redirect;

            // Wrap-around instance: free running, id_ready tied high.
            if (w_if_valid) begin
                check_eq("wrap_if_pc", w_if_pc, w_exp);
                check_eq("wrap_if_inst", w_if_inst, rom_fn(w_exp));
                w_exp = w_exp + 32'd4;
                w_pops++;
            end
            if (rst) w_exp = WRAP_PC;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        cycles(n);
        rst = 1'b0;
    endtask

    task automatic redirect_once(input bit br, input logic [31:0] ba,
                                 input bit ex, input logic [31:0] ea);
        branch_flag = br;
        branch_addr = ba;
        exc_flag    = ex;
        exc_addr    = ea;
        cycles(1);
        branch_flag = 1'b0;
        exc_flag    = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int issues;
        @(posedge clk);
        #1;
        checking = 1'b1;
        do_reset(2);

        // Free run: sequential fetch from INIT_PC, one pop per cycle.
        id_ready = 1'b1;
        cycles(12);

        // Backpressure from a fresh reset: exactly DEPTH issues, then drain.
        do_reset(1);
        id_ready = 1'b0;
        issues = 0;
        repeat (10) begin
            @(negedge clk);
            if (rom_en) issues++;
            @(posedge clk);
            #1;
        end
        check_eq("stall_issue_count", issues, DEPTH);
        id_ready = 1'b1;
        cycles(8);

        // Branch with misaligned target, then a simultaneous exception and branch.
        redirect_once(1'b1, 32'h0000_4002, 1'b0, 32'h0);
        cycles(6);
        redirect_once(1'b1, 32'h0000_0200, 1'b1, 32'h0000_0100);
        cycles(6);

        // Reset with three queued entries and a read in flight.
        id_ready = 1'b0;
        cycles(2);
        do_reset(1);
        id_ready = 1'b1;
        cycles(8);

        // Randomized traffic: light then heavy backpressure.
        for (int i = 0; i < 1200; i++) begin
            int r;
            id_ready = (i < 600) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
            r = $urandom_range(0, 99);
            branch_flag = (r < 6) || (r == 50);
            exc_flag    = (r >= 96) || (r == 50);
            branch_addr = $urandom;
            exc_addr    = $urandom;
            rst = ($urandom_range(0, 299) == 0);
            cycles(1);
        end
        rst = 1'b0;
        branch_flag = 1'b0;
        exc_flag = 1'b0;
        id_ready = 1'b1;
        cycles(6);

        checking = 1'b0;
        check_eq("wrap_pops_seen", {31'b0, w_pops >= 4}, 32'd1);
        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
